// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } muldiv_state_t;

    function automatic logic is_signed_op(input muldiv_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic is_div_op(input muldiv_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Core-side bundle of the multiply/divide unit: launch, HI/LO moves and results.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, srca, srcb, mthi, mtlo,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, srca, srcb, mthi, mtlo,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or the restoring divider.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_next
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_ext;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // Remainder after the left shift can carry into bit WIDTH; that bit alone proves rem >= divisor.
        rem_ext = acc[2*WIDTH-1:WIDTH-1];
        diff    = rem_ext - {1'b0, opnd};
        ge      = rem_ext[WIDTH] | ~diff[WIDTH];
        if (div_mode) begin
            if (ge) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_ext[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu unit with architectural HI/LO registers.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    muldiv_state_t      state;
    muldiv_op_t         op_q;
    muldiv_op_t         op_in;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opnd;
    logic               sign_a;
    logic               sign_b;
    logic               div_zero;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        op_in = muldiv_op_t'(bus.op);
        a_neg = is_signed_op(op_in) & bus.srca[WIDTH-1];
        b_neg = is_signed_op(op_in) & bus.srcb[WIDTH-1];
        a_mag = a_neg ? -bus.srca : bus.srca;
        b_mag = b_neg ? -bus.srcb : bus.srcb;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .opnd     (opnd),
        .div_mode (is_div_op(op_q)),
        .acc_next (acc_next)
    );

    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div_op(op_q)) begin
            if (div_zero) begin
                fix_hi = acc[2*WIDTH-1:WIDTH];
                fix_lo = acc[WIDTH-1:0];
            end else begin
                fix_hi = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                fix_lo = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= MULT;
            cnt      <= '0;
            opnd     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            acc      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mthi) hi_q <= bus.srca;
                    if (bus.mtlo) lo_q <= bus.srca;
                    if (bus.start) begin
                        op_q     <= op_in;
                        sign_a   <= a_neg;
                        sign_b   <= b_neg;
                        div_zero <= is_div_op(op_in) && (bus.srcb == '0);
                        // Low half seeds the multiplier or the dividend; the other operand stays fixed.
                        acc      <= {{WIDTH{1'b0}}, is_div_op(op_in) ? a_mag : b_mag};
                        opnd     <= is_div_op(op_in) ? b_mag : a_mag;
                        cnt      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    hi_q   <= fix_hi;
                    lo_q   <= fix_lo;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model plus literal vectors.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   cmp_on = 1'b0;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] r;
        longint      sp;
        int          sa;
        int          sb;
        int          q;
        int          m;
        logic [31:0] a_abs;
        r = '0;
        case (op)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                r  = sp;
            end
            2'b01: r = {32'b0, a} * {32'b0, b};
            2'b10: begin
                a_abs = a[31] ? -a : a;
                if (b == 32'd0) r = {a_abs, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    sa = $signed(a);
                    sb = $signed(b);
                    q  = sa / sb;
                    m  = sa % sb;
                    r  = {m, q};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    // Cycle-level expectation: an op accepted when idle retires W+1 edges later.
    int          m_left = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    logic        m_done = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left != 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                    m_done = 1'b1;
                end
            end else begin
                if (bus.mthi) m_hi = bus.srca;
                if (bus.mtlo) m_lo = bus.srca;
                if (bus.start) begin
                    m_left = W + 1;
                    {p_hi, p_lo} = ref_result(bus.op, bus.srca, bus.srcb);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cmp_busy", {31'b0, bus.busy}, {31'b0, m_left != 0});
            check("cmp_done", {31'b0, bus.done}, {31'b0, m_done});
            check("cmp_hi", bus.hi, m_hi);
            check("cmp_lo", bus.lo, m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch in the current cycle, wait for done, and pin the result to literals.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input bit with_mt, input bit disturb, input string name);
        int cyc;
        int busy_cnt;
        bus.op    = op;
        bus.srca  = a;
        bus.srcb  = b;
        bus.start = 1'b1;
        bus.mthi  = with_mt;
        bus.mtlo  = with_mt;
        tick();
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        cyc = 1;
        busy_cnt = 0;
        while (cyc < 60 && !bus.done) begin
            if (bus.busy) busy_cnt++;
            if (disturb && cyc == 5) begin
                bus.start = 1'b1;
                bus.op    = 2'b11;
                bus.srca  = 32'hDEAD;
                bus.srcb  = 32'd1;
                bus.mthi  = 1'b1;
                bus.mtlo  = 1'b1;
            end else begin
                bus.start = 1'b0;
                bus.mthi  = 1'b0;
                bus.mtlo  = 1'b0;
            end
            tick();
            cyc++;
        end
        check({name, "_done_cycle"}, cyc, 34);
        check({name, "_busy_cycles"}, busy_cnt, 33);
        check({name, "_busy_low"}, {31'b0, bus.busy}, 32'd0);
        check({name, "_hi"}, bus.hi, eh);
        check({name, "_lo"}, bus.lo, el);
    endtask

    initial begin
        int done_seen;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.srca  = '0;
        bus.srcb  = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_done", {31'b0, bus.done}, 32'd0);
        reset  = 1'b0;
        cmp_on = 1'b1;
        tick();

        run_op(MULT,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0, "mult_neg");
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0, "multu_max");
        run_op(MULTU, 32'd3,         32'd5,         32'd0,         32'd15,        0, 0, "multu_b2b");
        run_op(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         0, 0, "mult_minmin");
        run_op(DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, "div_neg");
        run_op(DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0, 0, "div_negdiv");
        run_op(DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1, 0, "divu_mt");
        run_op(DIVU,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         32'd1,         0, 0, "divu_big");
        run_op(DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 0, 0, "divu_zero");
        run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 0, 0, "div_ovf");
        run_op(MULTU, 32'd6,         32'd7,         32'd0,         32'd42,        0, 1, "ignore_busy");

        // Abort a run in its tenth cycle.
        bus.op    = 2'b01;
        bus.srca  = 32'h1234;
        bus.srcb  = 32'h10;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        #1;
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);

        bus.srca = 32'h1234;
        bus.mtlo = 1'b1;
        tick();
        bus.mtlo = 1'b0;
        check("mtlo_lo", bus.lo, 32'h1234);
        check("mtlo_hi", bus.hi, 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
